seq_gen_serial: RTL and testbench

Serial pattern transmitter, the source side of the serial sequence-detect path. It accepts a WIDTH-bit pattern through a start/ready handshake and shifts it out MSB-first, one bit per clock. It can repeat the frame with programmable idle gaps between frames. It drives the single-bit serial input of the 1011 sequence detector and serves as on-chip stimulus for it.

---
 rtl/seq_gen_serial_if.sv | 27 ++
 rtl/seq_gen_serial.sv | 126 ++++++++++++
 tb/tb_seq_gen_serial.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/seq_gen_serial_if.sv
// Handshake and serial-output bundle for seq_gen_serial.
interface seq_gen_serial_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
);
  logic             i_start;
  logic             o_ready;
  logic [WIDTH-1:0] i_pattern;
  logic [REP_W-1:0] i_repeat;
  logic [GAP_W-1:0] i_gap;
  logic             i_abort;
  logic             o_seq;
  logic             o_seq_valid;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_pattern, i_repeat, i_gap, i_abort,
    input  o_ready, o_seq, o_seq_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_pattern, i_repeat, i_gap, i_abort,
    output o_ready, o_seq, o_seq_valid, o_busy, o_done
  );
endinterface

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first,
// repeating it i_repeat+1 times with i_gap idle cycles between frames.
module seq_gen_serial #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seq_gen_serial_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [REP_W-1:0] frame_q, frame_d;
  logic [GAP_W-1:0] gap_len_q, gap_len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             seq_q, seq_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             reload;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    gap_len_d = gap_len_q;
    gap_d     = gap_q;
    seq_d     = 1'b0;
    vld_d     = 1'b0;
    done_d    = 1'b0;
    reload    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          pat_d     = bus.i_pattern;
          frame_d   = bus.i_repeat;
          gap_len_d = bus.i_gap;
          seq_d     = bus.i_pattern[WIDTH-1];
          vld_d     = 1'b1;
          shreg_d   = {bus.i_pattern[WIDTH-2:0], 1'b0};
          bit_d     = LAST_BIT;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
        end else if (bit_q != '0) begin
          seq_d   = shreg_q[WIDTH-1];
          vld_d   = 1'b1;
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          bit_d   = bit_q - CW'(1);
        end else if (frame_q != '0) begin
          frame_d = frame_q - REP_W'(1);
          if (gap_len_q != '0) begin
            // Counter is preloaded to gap-1 so the full GAP_W range never wraps.
            state_d = S_GAP;
            gap_d   = gap_len_q - GAP_W'(1);
          end else begin
            reload = 1'b1;
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (bus.i_abort)      state_d = S_IDLE;
        else if (gap_q == '0) reload  = 1'b1;
        else                  gap_d   = gap_q - GAP_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Next frame starts from the captured copy, never from live inputs.
    if (reload) begin
      seq_d   = pat_q[WIDTH-1];
      vld_d   = 1'b1;
      shreg_d = {pat_q[WIDTH-2:0], 1'b0};
      bit_d   = LAST_BIT;
      state_d = S_SHIFT;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      gap_len_q <= '0;
      gap_q     <= '0;
      seq_q     <= 1'b0;
      vld_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      pat_q     <= pat_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      gap_len_q <= gap_len_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_seq       = seq_q;
  assign bus.o_seq_valid = vld_q;
  assign bus.o_done      = done_q;
endmodule

// File: tb/tb_seq_gen_serial.sv
// Directed bench for seq_gen_serial: vector table of frame/gap/repeat cases plus
// hand sequences for ignore-while-busy, abort and asynchronous reset.
module tb_seq_gen_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  seq_gen_serial_if #(.WIDTH(4), .REP_W(4), .GAP_W(4)) bus ();

  seq_gen_serial #(.WIDTH(4), .REP_W(4), .GAP_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rep;
    logic [3:0]  gap;
    int          n_valid;   // valid cycles in the whole transfer
    int          done_cyc;  // cycle (1 = first after accept) of the o_done pulse
    int          n_det;     // 1011 occurrences seen by a detector on the valid bits
    logic [31:0] bits;      // last min(n_valid,32) valid bits, right-aligned
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          nv, det, idle_bad, busy_n, dcyc, dn;
    logic [31:0] got;
    logic [3:0]  hist;
    logic        rdy_after, seen;
    nv = 0; det = 0; idle_bad = 0; busy_n = 0; dcyc = 0; dn = 0;
    got = '0; hist = '0; rdy_after = 1'b0; seen = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_pre"}, 32'(bus.o_ready), 32'd1);
    bus.i_start = 1'b1; bus.i_pattern = v.pat; bus.i_repeat = v.rep; bus.i_gap = v.gap;
    @(negedge clk);
    // Scramble inputs while busy: captured values must be used throughout.
    bus.i_start = 1'b0; bus.i_pattern = ~v.pat; bus.i_repeat = ~v.rep; bus.i_gap = ~v.gap;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (bus.o_seq_valid) begin
        nv++;
        got  = {got[30:0], bus.o_seq};
        hist = {hist[2:0], bus.o_seq};
        if (hist == 4'b1011) det++;
      end else if (bus.o_seq) begin
        idle_bad++;
      end
      if (bus.o_busy) busy_n++;
      if (bus.o_done) begin dn++; dcyc = cyc; end
      if (dn > 0 && !bus.o_done) begin
        rdy_after = bus.o_ready; seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_finished"}, 32'(seen), 32'd1);
    chk({tag, "_nvalid"}, 32'(nv), 32'(v.n_valid));
    chk({tag, "_bits"}, got, v.bits);
    chk({tag, "_done_cyc"}, 32'(dcyc), 32'(v.done_cyc));
    chk({tag, "_done_cnt"}, 32'(dn), 32'd1);
    chk({tag, "_busy_span"}, 32'(busy_n), 32'(v.done_cyc));
    chk({tag, "_idle_low"}, 32'(idle_bad), 32'd0);
    chk({tag, "_det"}, 32'(det), 32'(v.n_det));
    chk({tag, "_ready_after"}, 32'(rdy_after), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, nv;
    vec_t vr;
    bus.i_start = 1'b0; bus.i_pattern = '0; bus.i_repeat = '0; bus.i_gap = '0; bus.i_abort = 1'b0;

    vecs[0] = '{4'b1011, 4'd0,  4'd0,  4,  5,   1,  32'hB};
    vecs[1] = '{4'b1011, 4'd2,  4'd0,  12, 13,  3,  32'hBBB};
    vecs[2] = '{4'b1011, 4'd1,  4'd3,  8,  12,  2,  32'hBB};
    vecs[3] = '{4'b1011, 4'd3,  4'd0,  16, 17,  4,  32'hBBBB};
    vecs[4] = '{4'b1011, 4'd15, 4'd15, 64, 290, 16, 32'hBBBBBBBB};
    vecs[5] = '{4'b0110, 4'd0,  4'd7,  4,  5,   0,  32'h6};
    vecs[6] = '{4'b1001, 4'd1,  4'd1,  8,  10,  0,  32'h99};
    vecs[7] = '{4'b0000, 4'd0,  4'd0,  4,  5,   0,  32'h0};
    vecs[8] = '{4'b1111, 4'd1,  4'd2,  8,  11,  0,  32'hFF};

    // Reset state, with a start request that must not be captured.
    bus.i_start = 1'b1; bus.i_pattern = 4'b1111;
    @(negedge clk);
    chk("rst_ready", 32'(bus.o_ready), 32'd1);
    chk("rst_valid", 32'(bus.o_seq_valid), 32'd0);
    chk("rst_seq",   32'(bus.o_seq), 32'd0);
    chk("rst_done",  32'(bus.o_done), 32'd0);
    chk("rst_busy",  32'(bus.o_busy), 32'd0);
    @(negedge clk);
    chk("rst_nocapture", 32'({bus.o_busy, bus.o_seq_valid}), 32'd0);
    bus.i_start = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start ignored while shifting, then abort at the second bit.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_pattern = 4'b1011; bus.i_repeat = 4'd0; bus.i_gap = 4'd0;
    @(negedge clk);
    chk("ab_bit1", 32'({bus.o_seq_valid, bus.o_seq}), 32'b11);
    bus.i_start = 1'b1; bus.i_pattern = 4'b0100;
    @(negedge clk);
    chk("ab_bit2", 32'({bus.o_seq_valid, bus.o_seq}), 32'b10);
    bus.i_start = 1'b0; bus.i_abort = 1'b1;
    @(negedge clk);
    bus.i_abort = 1'b0;
    chk("ab_line", 32'({bus.o_seq_valid, bus.o_seq}), 32'b00);
    chk("ab_ready", 32'(bus.o_ready), 32'd1);
    chk("ab_busy", 32'(bus.o_busy), 32'd0);
    dn = 0; nv = 0;
    for (int c = 0; c < 6; c++) begin
      dn += int'(bus.o_done); nv += int'(bus.o_seq_valid);
      @(negedge clk);
    end
    chk("ab_no_done", 32'(dn), 32'd0);
    chk("ab_no_valid", 32'(nv), 32'd0);

    // Abort wins over a simultaneous start in idle.
    bus.i_start = 1'b1; bus.i_abort = 1'b1; bus.i_pattern = 4'b1111;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_abort = 1'b0;
    chk("abst_busy", 32'({bus.o_busy, bus.o_seq_valid}), 32'd0);
    chk("abst_ready", 32'(bus.o_ready), 32'd1);

    // Asynchronous reset between edges mid-frame.
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_pattern = 4'b1011; bus.i_repeat = 4'd2; bus.i_gap = 4'd0;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    chk("ar_mid_valid", 32'(bus.o_seq_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_seq",   32'(bus.o_seq), 32'd0);
    chk("ar_valid", 32'(bus.o_seq_valid), 32'd0);
    chk("ar_busy",  32'(bus.o_busy), 32'd0);
    chk("ar_ready", 32'(bus.o_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    vr = '{4'b1101, 4'd0, 4'd0, 4, 5, 0, 32'hD};
    run_vec(vr, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
